// File: rtl/spi_quad_receiver.sv
// spi_quad_receiver: captures MSB-first quad-SPI frames (one nibble per sclk
// rising edge while cs is low) into a register of up to MAX_NIBBLES nibbles
// and reports each completed, non-empty frame with a one-clock valid pulse.
//
// Ports
//   clock        system clock, all state on its rising edge
//   reset        asynchronous, active-high reset
//   cs           frame select, active low, asynchronous to clock
//   sclk         serial clock, asynchronous to clock
//   sdio[3:0]    quad data lines, sampled on sclk rising edge
//   data_out     last completed frame, right-aligned
//   nibble_count nibbles captured in the last frame, saturating at MAX_NIBBLES
//   valid        one-clock pulse when data_out/nibble_count/overflow update
//   busy         high while a frame is being captured
//   overflow     last completed frame carried more than MAX_NIBBLES nibbles
//
// clock must run at least 4x sclk. SYNC_STAGES legal range is 2..3.
module spi_quad_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_NIBBLES = 16,
  localparam int unsigned DATA_W     = 4 * MAX_NIBBLES,
  localparam int unsigned CNT_W      = $clog2(MAX_NIBBLES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk,
  input  logic [3:0]        sdio,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  nibble_count,
  output logic              valid,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2,
    SKIP    = 2'd3
  } state_t;

  // Synchronizer chains; sdio shares the sclk depth so data stays aligned
  // with the detected edge.
  logic [SYNC_STAGES-1:0]      cs_sync;
  logic [SYNC_STAGES-1:0]      sclk_sync;
  logic [SYNC_STAGES-1:0][3:0] sdio_sync;
  logic                        sclk_prev;

  logic       cs_s;
  logic       sclk_s;
  logic [3:0] sdio_s;
  logic       sclk_rise;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // Input synchronizers and sclk edge history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      sdio_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], sdio};
      sclk_prev <= sclk_s;
    end
  end

  state_t              state_q, state_d;
  logic                post_rst_q;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   data_d;
  logic [CNT_W-1:0]    ncnt_d;
  logic                oflow_d;
  logic                valid_d;
  logic                busy_d;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_out;
    ncnt_d  = nibble_count;
    oflow_d = overflow;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Outside the first post-reset cycle, cs low here always means a
        // falling edge happened since cs was last seen high (possibly during
        // DONE). The synchronizer resets to 0, so the first post-reset cycle
        // always sees cs low and defers to SKIP until cs is seen high.
        if (!cs_s) begin
          if (post_rst_q) begin
            state_d = SKIP;
          end else begin
            state_d = RECEIVE;
            shift_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
      end
      RECEIVE: begin
        // cs release wins over a coincident sclk edge.
        if (cs_s) begin
          state_d = DONE;
        end else if (sclk_rise) begin
          if (cnt_q == CNT_W'(MAX_NIBBLES)) begin
            ovf_d = 1'b1;
          end else begin
            shift_d = {shift_q[DATA_W-5:0], sdio_s};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (cnt_q != '0) begin
          data_d  = shift_q;
          ncnt_d  = cnt_q;
          oflow_d = ovf_q;
          valid_d = 1'b1;
        end
      end
      SKIP: begin
        if (cs_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RECEIVE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      post_rst_q   <= 1'b1;
      shift_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      data_out     <= '0;
      nibble_count <= '0;
      overflow     <= 1'b0;
      valid        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      post_rst_q   <= 1'b0;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      data_out     <= data_d;
      nibble_count <= ncnt_d;
      overflow     <= oflow_d;
      valid        <= valid_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: doc/spi_quad_receiver.md
SPI_QUAD_RECEIVER -- requirements
Module: spi_quad_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on cs, sclk and sdio; legal range 2..3.
REQ-002 Parameter MAX_NIBBLES, default 16, capacity of the receive register in 4-bit nibbles.
REQ-003 clock  input  1  system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cs  input  1  frame select from the quad-SPI transmitter, active low, asynchronous to clock.
REQ-006 sclk  input  1  serial clock from the transmitter, asynchronous to clock.
REQ-007 sdio  input  4  quad data lines; one nibble per sclk rising edge.
REQ-008 data_out  output  4*MAX_NIBBLES (64)  last completed frame, right-aligned.
REQ-009 nibble_count  output  5  nibbles captured in the last completed frame, saturating at MAX_NIBBLES.
REQ-010 valid  output  1  one-clock pulse when data_out, nibble_count and overflow update.
REQ-011 busy  output  1  high while a frame is being captured.
REQ-012 overflow  output  1  last completed frame carried more than MAX_NIBBLES nibbles.

Function
REQ-013 cs, sclk and sdio SHALL each pass through SYNC_STAGES flops before any use; all references below are to synchronized signals.
REQ-014 An sclk rising edge SHALL be detected as synchronized sclk high with the previous-cycle value low.
REQ-015 The FSM SHALL have states IDLE, RECEIVE, DONE and SKIP.
REQ-016 IDLE: on cs falling (high to low), clear the shift register and counter and enter RECEIVE.
REQ-017 RECEIVE: on each detected sclk rising edge with cs low, shift = {shift[59:0], sdio}, counter increments by one.
REQ-018 First received nibble SHALL end up most significant among captured nibbles (MSB-first framing).
REQ-019 Once the counter reaches MAX_NIBBLES, further edges SHALL NOT modify the shift register; the counter holds and an internal overflow flag sets.
REQ-020 RECEIVE: on cs high, go to DONE; an sclk edge detected in that same cycle SHALL be ignored.
REQ-021 DONE (one cycle): if counter nonzero, load data_out, nibble_count and overflow and pulse valid; if zero, outputs hold and valid stays low; then go to IDLE.
REQ-022 End-to-end latency: valid SHALL rise SYNC_STAGES+2 clocks after the cs input rises.
REQ-023 busy SHALL be high exactly in RECEIVE.
REQ-024 data_out, nibble_count and overflow SHALL hold their values between valid pulses.
REQ-025 A cs falling edge in DONE SHALL be recognized in the following IDLE cycle; no frame is lost.
REQ-026 clock SHALL be at least 4x sclk; slower clock ratios are unsupported.

Reset
REQ-027 While reset is high: state IDLE; data_out 0; nibble_count 0; valid 0; busy 0; overflow 0; synchronizers and shift register 0.
REQ-028 After reset release, if synchronized cs is low, the FSM SHALL enter SKIP and ignore all sclk edges until cs is high, then return to IDLE.
REQ-029 Reset mid-frame SHALL discard the partial frame with no valid pulse.

Verification
REQ-030 10-nibble frame, transmitter sends 9,8,...,0 -> one valid pulse, data_out 0x0000009876543210, nibble_count 10, overflow 0.
REQ-031 16 nibbles F..0 -> data_out 0xFEDCBA9876543210, nibble_count 16, overflow 0.
REQ-032 18 nibbles 1,2,...,F,0,A,B -> data_out holds the first 16 (0x123456789ABCDEF0), nibble_count 16, overflow 1.
REQ-033 cs low then high with no sclk edges -> no valid pulse, outputs keep previous frame values.
REQ-034 reset asserted after 5 nibbles of a 10-nibble frame and released while cs still low -> no valid for that frame, busy 0 until next cs fall, next 3-nibble frame 0xA,0xB,0xC yields data_out 0xABC, nibble_count 3.
REQ-035 Back-to-back frames with cs high for 3 clocks -> both frames reported with correct values, two valid pulses, latency per REQ-022.
